bcd_counter_multi: RTL

//  Parametrised multi-digit decimal (BCD) up/down counter with built-in tick prescaler,

---
 rtl/bcd_counter_multi_if.sv | 24 ++
 rtl/bcd_counter_multi.sv | 121 ++++++++++++
 2 files changed

// File: rtl/bcd_counter_multi_if.sv
// Control and display bundle for bcd_counter_multi.
// The master drives enable, direction and the preset. The slave (the counter) returns the count,
// the wrap pulse and the segment drive.
interface bcd_counter_multi_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  enable;
  logic                  up_down;
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic [4*DIGITS-1:0]   count;
  logic                  wrap;
  logic [7*DIGITS-1:0]   HEX;

  modport master (
    output enable, up_down, load, load_value,
    input  count, wrap, HEX
  );

  modport slave (
    input  enable, up_down, load, load_value,
    output count, wrap, HEX
  );
endinterface

// File: rtl/bcd_counter_multi.sv
// Multi-digit BCD up/down counter with a tick prescaler, a synchronous preset and a wrap pulse.
// It also drives active-low 7-segment outputs, one digit per display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module bcd_counter_multi #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input logic               CLOCK_50,
  input logic               reset,
  bcd_counter_multi_if.slave bus
);

  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);

  logic [PreW-1:0]     r_pre;
  logic [4*DIGITS-1:0] r_count;
  logic                r_wrap;

  logic                w_tick;
  logic                w_roll;
  logic [4*DIGITS-1:0] w_step;
  logic [4*DIGITS-1:0] w_clamped;
  logic [7*DIGITS-1:0] w_hex;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign w_tick = bus.enable && (r_pre == PreMax);

  // Ripple carry/borrow through the digits; a carry out of the top digit is a full rollover.
  always_comb begin
    logic       c;
    logic [3:0] d;
    w_step = r_count;
    c      = 1'b1;
    d      = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d = r_count[4*i +: 4];
      if (c) begin
        if (bus.up_down) begin
          if (d >= 4'd9) begin
            w_step[4*i +: 4] = 4'd0;
          end else begin
            w_step[4*i +: 4] = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            w_step[4*i +: 4] = 4'd9;
          end else begin
            w_step[4*i +: 4] = d - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    w_roll = c;
  end

  // Preset digits above 9 are clamped so count never holds a non-BCD code.
  always_comb begin
    w_clamped = bus.load_value;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bus.load_value[4*i +: 4] > 4'd9) w_clamped[4*i +: 4] = 4'd9;
    end
  end

  // Segment decode straight from the registered count.
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    w_hex = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      w_hex[7*i +: 7] = seg7(r_count[4*i +: 4]);
    end
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      lead = lead && (r_count[4*i +: 4] == 4'd0);
      if (lead) w_hex[7*i +: 7] = 7'h7F;
    end
`endif
  end

  // Count, prescaler and wrap state; load wins over a coincident tick.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_pre   <= '0;
      r_wrap  <= 1'b0;
    end else if (bus.load) begin
      r_count <= w_clamped;
      r_pre   <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= w_tick && w_roll;
      if (bus.enable) r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) r_count <= w_step;
    end
  end

  assign bus.count = r_count;
  assign bus.wrap  = r_wrap;
  assign bus.HEX   = w_hex;

endmodule
